// File: rtl/vc_mem_net_adapter.sv
// vc_mem_net_adapter: bridges a request/response network port to one memory bank.
// Latency: request path 0 cycles; response path 0 cycles (1 cycle with the output register).
// Backpressure: requests stall when the src-id FIFO is full (unless a response frees a slot
//   that cycle); responses stall on respnet_rdy and are refused while nothing is outstanding.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   reqnet_msg/val/rdy   (in/in/out)   {dest, src, memreq payload} from the request network
//   memreq_msg/val/rdy   (out/out/in)  memory request payload to the bank
//   memresp_msg/val/rdy  (in/in/out)   memory response from the bank (in request order)
//   respnet_msg/val/rdy  (out/out/in)  {dest, src, memresp payload} to the response network
//
// Build option: define VC_MEM_NET_ADAPTER_RESP_BUF_EN to register respnet_msg/respnet_val
// through a one-entry output buffer.
//
// Payload layouts: memreq = {type, addr, data}, memresp = {type, data}.

module vc_mem_net_adapter #(
  parameter  int p_router_id      = 0,
  parameter  int p_num_nodes      = 4,
  parameter  int p_addr_sz        = 8,
  parameter  int p_data_sz        = 32,
  parameter  int p_max_requests   = 4,
  localparam int c_srcdest_sz     = (p_num_nodes > 1) ? $clog2(p_num_nodes) : 1,
  localparam int c_memreq_msg_sz  = 1 + p_addr_sz + p_data_sz,
  localparam int c_memresp_msg_sz = 1 + p_data_sz,
  localparam int c_reqnet_msg_sz  = 2*c_srcdest_sz + c_memreq_msg_sz,
  localparam int c_respnet_msg_sz = 2*c_srcdest_sz + c_memresp_msg_sz
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic [c_reqnet_msg_sz-1:0]  reqnet_msg,
  input  logic                        reqnet_val,
  output logic                        reqnet_rdy,

  output logic [c_memreq_msg_sz-1:0]  memreq_msg,
  output logic                        memreq_val,
  input  logic                        memreq_rdy,

  input  logic [c_memresp_msg_sz-1:0] memresp_msg,
  input  logic                        memresp_val,
  output logic                        memresp_rdy,

  output logic [c_respnet_msg_sz-1:0] respnet_msg,
  output logic                        respnet_val,
  input  logic                        respnet_rdy
);

  localparam int c_cnt_sz = $clog2(32);
  localparam int c_ptr_sz = (p_max_requests > 1) ? $clog2(p_max_requests) : 1;
  localparam logic [c_cnt_sz-1:0] c_max_cnt  = c_cnt_sz'(p_max_requests);
  localparam logic [c_ptr_sz-1:0] c_last_ptr = c_ptr_sz'(p_max_requests - 1);
  localparam logic [c_srcdest_sz-1:0] c_my_id = c_srcdest_sz'(p_router_id);

  logic [c_cnt_sz-1:0]     count_q, count_d;
  logic [c_ptr_sz-1:0]     head_q, head_d;
  logic [c_ptr_sz-1:0]     tail_q, tail_d;
  logic [c_srcdest_sz-1:0] srcid_q [p_max_requests];

  logic                    req_fire, resp_fire, can_enq, outstanding;
  logic [c_srcdest_sz-1:0] req_src;
  logic [c_respnet_msg_sz-1:0] resp_msg;

  function automatic logic [c_ptr_sz-1:0] ptr_inc(input logic [c_ptr_sz-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  assign req_src     = reqnet_msg[c_memreq_msg_sz +: c_srcdest_sz];
  assign memreq_msg  = reqnet_msg[c_memreq_msg_sz-1:0];

  // Outputs read the pre-reset count while reset is held, so gate on reset explicitly:
  // nothing is outstanding and the request path is fully open during reset.
  assign outstanding = !reset && (count_q != '0);
  assign resp_fire   = memresp_val && memresp_rdy;
  assign can_enq     = reset || (count_q < c_max_cnt) || resp_fire;

  assign memreq_val  = reqnet_val && can_enq;
  assign reqnet_rdy  = memreq_rdy && can_enq;
  assign req_fire    = reqnet_val && reqnet_rdy;

  assign resp_msg    = {srcid_q[head_q], c_my_id, memresp_msg};

`ifdef VC_MEM_NET_ADAPTER_RESP_BUF_EN
  logic                        buf_val_q, buf_val_d;
  logic [c_respnet_msg_sz-1:0] buf_msg_q, buf_msg_d;

  // The buffer may accept a new response in the same cycle the old one drains.
  assign memresp_rdy = outstanding && (!buf_val_q || respnet_rdy);
  assign respnet_val = buf_val_q && !reset;
  assign respnet_msg = buf_msg_q;

  always_comb begin
    buf_val_d = buf_val_q;
    buf_msg_d = buf_msg_q;
    if (resp_fire) begin
      buf_val_d = 1'b1;
      buf_msg_d = resp_msg;
    end else if (respnet_val && respnet_rdy) begin
      buf_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_val_q <= 1'b0;
    end else begin
      buf_val_q <= buf_val_d;
      buf_msg_q <= buf_msg_d;
    end
  end
`else
  assign memresp_rdy = respnet_rdy && outstanding;
  assign respnet_val = memresp_val && outstanding;
  assign respnet_msg = resp_msg;
`endif

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (req_fire)  tail_d = ptr_inc(tail_q);
    if (resp_fire) head_d = ptr_inc(head_q);
    case ({req_fire, resp_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Storage needs no reset: entries are only read between head and tail.
  always_ff @(posedge clk) begin
    if (!reset && req_fire) srcid_q[tail_q] <= req_src;
  end

endmodule

// File: tb/tb_vc_mem_net_adapter.sv
// Directed bench for vc_mem_net_adapter with 4 nodes, router id 2, two outstanding requests.
// Inputs are driven 1 time unit after the rising edge; outputs are checked 1 unit later.

module tb_vc_mem_net_adapter;

  localparam int NS   = 2;
  localparam int REQP = 1 + 8 + 32;
  localparam int RSPP = 1 + 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [2*NS+REQP-1:0] reqnet_msg;
  logic             reqnet_val, reqnet_rdy;
  logic [REQP-1:0]  memreq_msg;
  logic             memreq_val, memreq_rdy;
  logic [RSPP-1:0]  memresp_msg;
  logic             memresp_val, memresp_rdy;
  logic [2*NS+RSPP-1:0] respnet_msg;
  logic             respnet_val, respnet_rdy;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  vc_mem_net_adapter #(
    .p_router_id   (2),
    .p_num_nodes   (4),
    .p_addr_sz     (8),
    .p_data_sz     (32),
    .p_max_requests(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .reqnet_msg (reqnet_msg),
    .reqnet_val (reqnet_val),
    .reqnet_rdy (reqnet_rdy),
    .memreq_msg (memreq_msg),
    .memreq_val (memreq_val),
    .memreq_rdy (memreq_rdy),
    .memresp_msg(memresp_msg),
    .memresp_val(memresp_val),
    .memresp_rdy(memresp_rdy),
    .respnet_msg(respnet_msg),
    .respnet_val(respnet_val),
    .respnet_rdy(respnet_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rsp(input logic [1:0] dest, input logic [31:0] d);
    logic [36:0] m;
    m = {dest, 2'd2, 1'b0, d};
    return 64'(m);
  endfunction

  // Present a request from src; expect accept/stall, then hold one edge and drop valid.
  task automatic do_req(input logic [1:0] src, input logic [7:0] addr, input logic exp_rdy);
    logic [REQP-1:0] pl;
    pl = {1'b1, addr, 32'h1000_0000 | 32'(addr)};
    reqnet_msg = {2'd2, src, pl};
    reqnet_val = 1'b1;
    #1;
    chk("memreq_msg", 64'(memreq_msg), 64'(pl));
    chk("reqnet_rdy", 64'(reqnet_rdy), 64'(exp_rdy));
    chk("memreq_val", 64'(memreq_val), 64'(exp_rdy));
    tick();
    reqnet_val = 1'b0;
  endtask

  // One response with respnet_rdy high; routed back to exp_dest.
  task automatic do_resp(input logic [31:0] d, input logic [1:0] exp_dest);
    memresp_msg = {1'b0, d};
    memresp_val = 1'b1;
    #1;
    chk("memresp_rdy", 64'(memresp_rdy), 64'd1);
`ifdef VC_MEM_NET_ADAPTER_RESP_BUF_EN
    tick();
    memresp_val = 1'b0;
    #1;
    chk("respnet_val", 64'(respnet_val), 64'd1);
    chk("respnet_msg", 64'(respnet_msg), rsp(exp_dest, d));
    tick();
`else
    chk("respnet_val", 64'(respnet_val), 64'd1);
    chk("respnet_msg", 64'(respnet_msg), rsp(exp_dest, d));
    tick();
    memresp_val = 1'b0;
`endif
  endtask

  initial begin
    reset       = 1'b1;
    reqnet_msg  = '0;
    reqnet_val  = 1'b0;
    memreq_rdy  = 1'b1;
    memresp_msg = '0;
    memresp_val = 1'b0;
    respnet_rdy = 1'b1;
    tick();
    tick();

    // During reset the request path is transparent and the response path closed.
    reqnet_val  = 1'b1;
    memresp_val = 1'b1;
    #1;
    chk("rst memreq_val", 64'(memreq_val), 64'd1);
    chk("rst reqnet_rdy", 64'(reqnet_rdy), 64'd1);
    chk("rst memresp_rdy", 64'(memresp_rdy), 64'd0);
    chk("rst respnet_val", 64'(respnet_val), 64'd0);
    memreq_rdy = 1'b0;
    #1;
    chk("rst rdy follows", 64'(reqnet_rdy), 64'd0);
    memreq_rdy = 1'b1;
    tick();

    // Released: stray response with nothing outstanding is never taken.
    reset      = 1'b0;
    reqnet_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("orphan memresp_rdy", 64'(memresp_rdy), 64'd0);
      chk("orphan respnet_val", 64'(respnet_val), 64'd0);
      tick();
    end
    memresp_val = 1'b0;

    // Basic round trip.
    do_req(2'd1, 8'h40, 1'b1);
    do_resp(32'h0000_CAFE, 2'd1);

    // Fill, stall the third request, drain in order, then the third goes.
    do_req(2'd0, 8'h10, 1'b1);
    do_req(2'd3, 8'h20, 1'b1);
    do_req(2'd1, 8'h30, 1'b0);
    do_resp(32'h1111_0000, 2'd0);
    do_resp(32'h2222_0000, 2'd3);
    do_req(2'd1, 8'h30, 1'b1);

    // Full, request and response fire together; count must stay at 2.
    do_req(2'd2, 8'h50, 1'b1);
    reqnet_msg  = {2'd2, 2'd3, 1'b1, 8'h60, 32'h1000_0060};
    reqnet_val  = 1'b1;
    memresp_msg = {1'b0, 32'h3333_0000};
    memresp_val = 1'b1;
    #1;
    chk("both reqnet_rdy", 64'(reqnet_rdy), 64'd1);
    chk("both memresp_rdy", 64'(memresp_rdy), 64'd1);
`ifndef VC_MEM_NET_ADAPTER_RESP_BUF_EN
    chk("both respnet_msg", 64'(respnet_msg), rsp(2'd1, 32'h3333_0000));
`endif
    tick();
    reqnet_val  = 1'b0;
    memresp_val = 1'b0;
`ifdef VC_MEM_NET_ADAPTER_RESP_BUF_EN
    #1;
    chk("both respnet_msg", 64'(respnet_msg), rsp(2'd1, 32'h3333_0000));
    tick();
`endif
    do_req(2'd0, 8'h70, 1'b0);
    do_resp(32'h4444_0000, 2'd2);
    do_resp(32'h5555_0000, 2'd3);

    // Reset with one request outstanding discards it.
    do_req(2'd1, 8'h80, 1'b1);
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    memresp_val = 1'b1;
    #1;
    chk("post-rst memresp_rdy", 64'(memresp_rdy), 64'd0);
    chk("post-rst respnet_val", 64'(respnet_val), 64'd0);
    memresp_val = 1'b0;
    tick();
    do_req(2'd3, 8'h90, 1'b1);
    do_resp(32'h6666_0000, 2'd3);

    // Response-network backpressure for three cycles.
    do_req(2'd0, 8'hA0, 1'b1);
    do_req(2'd1, 8'hB0, 1'b1);
    respnet_rdy = 1'b0;
    memresp_msg = {1'b0, 32'hAAAA_0000};
    memresp_val = 1'b1;
`ifdef VC_MEM_NET_ADAPTER_RESP_BUF_EN
    #1;
    chk("bp load rdy", 64'(memresp_rdy), 64'd1);
    tick();
    memresp_msg = {1'b0, 32'hBBBB_0000};
`endif
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp respnet_val", 64'(respnet_val), 64'd1);
      chk("bp respnet_msg", 64'(respnet_msg), rsp(2'd0, 32'hAAAA_0000));
      chk("bp memresp_rdy", 64'(memresp_rdy), 64'd0);
      tick();
    end
    respnet_rdy = 1'b1;
    #1;
    chk("bp release rdy", 64'(memresp_rdy), 64'd1);
    chk("bp release msg", 64'(respnet_msg), rsp(2'd0, 32'hAAAA_0000));
    tick();
`ifdef VC_MEM_NET_ADAPTER_RESP_BUF_EN
    memresp_val = 1'b0;
    #1;
    chk("bp second msg", 64'(respnet_msg), rsp(2'd1, 32'hBBBB_0000));
    chk("bp second val", 64'(respnet_val), 64'd1);
    tick();
    #1;
    chk("bp drained val", 64'(respnet_val), 64'd0);
`else
    memresp_val = 1'b0;
    do_resp(32'hBBBB_0000, 2'd1);
    memresp_val = 1'b1;
    #1;
    chk("bp drained rdy", 64'(memresp_rdy), 64'd0);
    memresp_val = 1'b0;
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
